// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake/data bundle for sync_fifo_param.
//   master modport : the producer/consumer side (drives data_in, put, get, clear_err).
//   slave modport  : the FIFO side (drives data_out, data_valid, fillcount and status flags).
// Parameters WIDTH and DEPTH must match the attached FIFO instance.
interface sync_fifo_param_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_in;
  logic             put;
  logic             get;
  logic             clear_err;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [CW-1:0]    fillcount;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, put, get, clear_err,
    input  data_out, data_valid, fillcount, empty, full,
    input  almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  data_in, put, get, clear_err,
    output data_out, data_valid, fillcount, empty, full,
    output almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with programmable almost-full/almost-empty
// flags, sticky overflow/underflow error flags and an output-valid strobe.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset (0 = reset)
//   bus    - sync_fifo_param_if.slave: data_in/put/get/clear_err in;
//            data_out/data_valid/fillcount/empty/full/almost_empty/almost_full/
//            overflow/underflow out
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (data_out shows the
// head word whenever the FIFO is non-empty). Undefined gives a registered 1-cycle read.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sync_fifo_param_if.slave      bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Configuration checks, reported at elaboration (time 0).
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL=%0d out of range 1..DEPTH", AF_LEVEL);
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL=%0d out of range 0..DEPTH-1", AE_LEVEL);
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty, full;
  logic             get_ok, put_ok;
  logic [WIDTH-1:0] head_word;

  // Flags decode the registered count only, so they move on clock edges.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_word = mem_q[rd_ptr_q];

  // A put into a full FIFO is allowed only when a pop frees a slot in the same cycle.
  assign get_ok = bus.get & ~empty;
  assign put_ok = bus.put & (~full | get_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (put_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (get_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({put_ok, get_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new error in the same cycle as clear_err wins.
  always_comb begin
    ovf_d = (bus.put & ~put_ok) | (ovf_q & ~bus.clear_err);
    unf_d = (bus.get & ~get_ok) | (unf_q & ~bus.clear_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (put_ok) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Remember the displayed head so data_out holds the last word once the FIFO drains.
  always_comb begin
    dout_d = empty ? dout_q : head_word;
  end

  assign bus.data_out   = empty ? dout_q : head_word;
  assign bus.data_valid = ~empty;
`else
  logic valid_q, valid_d;

  always_comb begin
    dout_d  = get_ok ? head_word : dout_q;
    valid_d = get_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = valid_q;
`endif

  assign bus.fillcount    = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (32'(count_q) <= AE_LEVEL);
  assign bus.almost_full  = (32'(count_q) >= AF_LEVEL);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed, table-driven bench for sync_fifo_param at default parameters.
module tb_sync_fifo_param;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_if ();

  sync_fifo_param #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AF_LEVEL(12),
    .AE_LEVEL(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (fifo_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        put;
    logic        get;
    logic        clr;
    logic [31:0] din;
    int          cnt;
    logic [31:0] dout;
    logic        vld;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic p, input logic g, input logic c,
                              input logic [31:0] d, input int cnt, input logic [31:0] dout,
                              input logic vld, input logic ovf, input logic unf);
    vec_t v;
    v.name = nm; v.put = p; v.get = g; v.clr = c; v.din = d; v.cnt = cnt;
    v.dout = dout; v.vld = vld; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Check every output against expected count/data; flags come from the expected count.
  task automatic chk_state(input string nm, input int cnt, input logic [31:0] dout,
                           input logic vld, input logic ovf, input logic unf);
    chk({nm, ".fillcount"},    32'(fifo_if.fillcount),    32'(cnt));
    chk({nm, ".empty"},        32'(fifo_if.empty),        32'(cnt == 0));
    chk({nm, ".full"},         32'(fifo_if.full),         32'(cnt == 16));
    chk({nm, ".almost_empty"}, 32'(fifo_if.almost_empty), 32'(cnt <= 2));
    chk({nm, ".almost_full"},  32'(fifo_if.almost_full),  32'(cnt >= 12));
    chk({nm, ".data_out"},     fifo_if.data_out,          dout);
    chk({nm, ".data_valid"},   32'(fifo_if.data_valid),   32'(vld));
    chk({nm, ".overflow"},     32'(fifo_if.overflow),     32'(ovf));
    chk({nm, ".underflow"},    32'(fifo_if.underflow),    32'(unf));
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic cycle(input logic p, input logic g, input logic c, input logic [31:0] d);
    @(negedge clk);
    fifo_if.put       = p;
    fifo_if.get       = g;
    fifo_if.clear_err = c;
    fifo_if.data_in   = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    fifo_if.put       = 1'b0;
    fifo_if.get       = 1'b0;
    fifo_if.clear_err = 1'b0;
  endtask

  task automatic step(input logic p, input logic g, input logic c, input logic [31:0] d);
    @(negedge clk);
    fifo_if.put       = p;
    fifo_if.get       = g;
    fifo_if.clear_err = c;
    fifo_if.data_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] last;
    logic [31:0] base;
    n_cmp = 0;
    n_bad = 0;
    fifo_if.put       = 1'b0;
    fifo_if.get       = 1'b0;
    fifo_if.clear_err = 1'b0;
    fifo_if.data_in   = '0;

    do_reset();
    chk_state("reset", 0, 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef SYNC_FIFO_FWFT_EN
    step(1'b1, 1'b0, 1'b0, 32'h12345678);
    chk_state("fwft_put", 1, 32'h12345678, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk_state("fwft_idle", 1, 32'h12345678, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("fwft_get", 0, 32'h12345678, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'hA1);
    step(1'b1, 1'b0, 1'b0, 32'hB2);
    chk_state("fwft_two", 2, 32'hA1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("fwft_pop1", 1, 32'hB2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'hC3);
    chk_state("fwft_pp", 1, 32'hC3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("fwft_drain", 0, 32'hC3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("fwft_unf", 0, 32'hC3, 1'b0, 1'b0, 1'b1);
`else
    // Fill 0..15: almost_full first rises at count 12, full on the 16th.
    for (int i = 0; i < 16; i++) add("fill", 1, 0, 0, 32'(i), i + 1, 32'h0, 0, 0, 0);
    add("put_full",      1, 0, 0, 32'hDEADBEEF, 16, 32'h0, 0, 1, 0);
    add("clr_ovf",       0, 0, 1, 32'h0,        16, 32'h0, 0, 0, 0);
    add("put_get_full",  1, 1, 0, 32'hCCCCCCCC, 16, 32'h0, 1, 0, 0);
    // Remaining words 1..15, then CCCCCCCC last.
    for (int k = 0; k < 16; k++)
      add("drain", 0, 1, 0, 32'h0, 15 - k, (k < 15) ? 32'(k + 1) : 32'hCCCCCCCC, 1, 0, 0);
    add("put_get_empty", 1, 1, 0, 32'h55, 1, 32'hCCCCCCCC, 0, 0, 1);
    add("pop_55",        0, 1, 0, 32'h0,  0, 32'h55,       1, 0, 1);
    add("clr_vs_unf",    0, 1, 1, 32'h0,  0, 32'h55,       0, 0, 1);
    add("clr_unf",       0, 0, 1, 32'h0,  0, 32'h55,       0, 0, 0);
    last = 32'h55;
    for (int r = 0; r < 3; r++) begin
      base = {4{8'hAA + 8'(8'h11 * r)}};
      for (int j = 0; j < 10; j++) add("wrap_put", 1, 0, 0, base + 32'(j), j + 1, last, 0, 0, 0);
      for (int j = 0; j < 10; j++) add("wrap_get", 0, 1, 0, 32'h0, 9 - j, base + 32'(j), 1, 0, 0);
      last = base + 32'd9;
    end

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].put, vecs[n].get, vecs[n].clr, vecs[n].din);
      chk_state($sformatf("%s[%0d]", vecs[n].name, n), vecs[n].cnt, vecs[n].dout, vecs[n].vld,
                vecs[n].ovf, vecs[n].unf);
    end

    // Asynchronous reset mid-operation discards stored words without a clock edge.
    step(1'b1, 1'b0, 1'b0, 32'h1111);
    step(1'b1, 1'b0, 1'b0, 32'h2222);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("pre_rst", 1, 32'h1111, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    fifo_if.get = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("get_after_rst", 0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Overflow set in the same cycle as clear_err stays set.
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 32'(100 + i));
    step(1'b1, 1'b0, 1'b1, 32'h77);
    chk_state("clr_vs_ovf", 16, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_state("after_ovf_pop", 15, 32'd100, 1'b1, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
